fifo_burst_reader: RTL
======================

# fifo_burst_reader

Read-side companion to the team's valid/ready `fifo`. It drains the FIFO's `data_out`/`data_out_val`/`data_out_rdy` port into a local burst buffer. It re-emits the words as framed bursts of `BURST_LEN` beats, with a `last` marker and a length field. Sits between a FIFO and any packet-oriented consumer. An optional idle timeout flushes partial bursts.

## Interface
- `WIDTH`, 8, data word width in bits
- `BURST_LEN`, 4, words per full burst; legal range ≥ 2
- `TIMEOUT`, 16, idle cycles before a partial burst is flushed; legal range ≥ 1; ignored without the macro
- `CW`, `$clog2(BURST_LEN+1)`, width of count/length fields; derived, never overridden
- `clk`  in  1  single clock, all state updates on posedge
- `reset`  in  1  synchronous, active-high
- `data_in`  in  WIDTH  word from FIFO `data_out`
- `data_in_val`  in  1  from FIFO `data_out_val`
- `data_in_rdy`  out  1  to FIFO `data_out_rdy`
- `data_out`  out  WIDTH  current burst beat
- `data_out_val`  out  1  beat valid
- `data_out_rdy`  in  1  downstream ready
- `data_out_last`  out  1  final beat of burst
- `data_out_len`  out  CW  number of beats in current burst (1..BURST_LEN)

## Operation
- Two-state FSM: COLLECT, SEND. Single buffer of `BURST_LEN` × `WIDTH`, so collection and sending never overlap.
- Handshakes:
  - Input handshake: accept = `data_in_val && data_in_rdy`.
  - Output handshake: fire = `data_out_val && data_out_rdy`.
- COLLECT:
  - `data_in_rdy`=1, `data_out_val`=0.
  - On accept: store `data_in` at `buf[wr_cnt]`, then `wr_cnt++`.
  - The accept that makes `wr_cnt`==`BURST_LEN` latches `len`=`BURST_LEN`, clears `rd_idx`, and enters SEND.
- SEND:
  - `data_in_rdy`=0, `data_out_val`=1.
  - `data_out`=`buf[rd_idx]`, `data_out_len`=`len`, `data_out_last`=(`rd_idx`==`len`−1).
  - On fire: `rd_idx++`.
  - On fire with last: clear `wr_cnt` and enter COLLECT.
- Stall: while `data_out_val && !data_out_rdy`, `data_out`, `data_out_last` and `data_out_len` are held stable.
- `data_out_last`, `data_out_len` and `data_out` are 0 in COLLECT.
- Counters never wrap: `wr_cnt` ∈ [0,`BURST_LEN`], `rd_idx` ∈ [0,`len`−1].
- The FIFO's `empty` and `almost_empty` signals are not used. Flow control relies solely on valid/ready.

## Timing
- Reset (sync, sampled at posedge):
  - State=COLLECT; `wr_cnt`, `rd_idx`, `len`, idle counter=0; buffer contents don't care.
  - While `reset` is high: `data_in_rdy`=0, `data_out_val`=0, `data_out_last`=0, `data_out_len`=0, `data_out`=0.
- First cycle after reset deasserts: `data_in_rdy`=1.
- Reset mid-burst, in either state: buffered words are discarded and no partial burst is emitted.
- Latency:
  - Final accept at edge N → `data_out_val` high in the cycle after N.
  - The first beat can fire at edge N+1.
- Throughput: one word per cycle on each side. The minimum burst period is 2×`BURST_LEN` cycles.
- `data_in_rdy` is purely a function of the FSM state register, with no combinational path from `data_out_rdy`.
- Simultaneous `data_in_val` and SEND: the word is not accepted (`rdy`=0) and stays in the FIFO.
- Back-to-back bursts: last fire at edge M → `data_in_rdy`=1 in the cycle after M.

## Configuration
- Macro `FIFO_BURST_READER_TIMEOUT_EN`.
- Defined: an idle counter runs in COLLECT whenever `wr_cnt`>0.
  - It clears on every accept and increments on every cycle without an accept.
  - If it reaches `TIMEOUT` with no accept, the block latches `len`=`wr_cnt` and enters SEND. With the last accept at edge A and no further input, SEND begins at edge A+`TIMEOUT`.
  - An accept in the same cycle as the expiry wins: the word is stored and the counter is cleared.
  - A zero-length burst is never emitted.
- Undefined: there is no idle counter. Only full `BURST_LEN` bursts are emitted, and a partial burst waits indefinitely. The `TIMEOUT` parameter is unused.

## Test plan
- Full burst, no stalls (`BURST_LEN`=4): feed 0x11,0x22,0x33,0x44 on consecutive cycles with `data_out_rdy`=1.
  - Expect four beats 0x11..0x44 on the next four cycles.
  - Expect `last` only on 0x44, `len`=4, and `data_in_rdy`=0 throughout SEND.
- Downstream stall: same as above, but hold `data_out_rdy`=0 for 5 cycles at beat 2.
  - Expect 0x22, `last`=0 and `len`=4 held stable.
  - Expect no beat lost or duplicated.
- Random valid/ready for 200 cycles, both sides random, 8-bit data.
  - Expect output order to equal input order.
  - Expect each burst to be 4 beats with exactly one `last`.
- Reset mid-SEND after 2 beats fired.
  - Expect all outputs 0 during reset and `data_in_rdy`=1 the cycle after reset.
  - Expect the next burst to contain only post-reset words.
- With `FIFO_BURST_READER_TIMEOUT_EN` and `TIMEOUT`=16: feed 0xA1,0xA2, then hold `data_in_val`=0.
  - Expect `data_out_val` to rise 16 edges after the 0xA2 accept.
  - Expect `len`=2 and `last` on 0xA2.
  - Without the macro, expect no output after 100 idle cycles.
- Timeout tie (macro defined): present an accept exactly on the expiry cycle.
  - Expect no flush, `wr_cnt` incremented, and the idle counter restarting from 0.

Source files
------------

// File: rtl/fifo_burst_reader.sv
// Drains a valid/ready FIFO into a single burst buffer and replays it as framed bursts (last/len).
// Define FIFO_BURST_READER_TIMEOUT_EN to flush a partial burst after TIMEOUT idle cycles.
module fifo_burst_reader #(
    parameter int WIDTH     = 8,
    parameter int BURST_LEN = 4,
    parameter int TIMEOUT   = 16,
    localparam int CW       = $clog2(BURST_LEN + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_in_val,
    output logic             data_in_rdy,
    output logic [WIDTH-1:0] data_out,
    output logic             data_out_val,
    input  logic             data_out_rdy,
    output logic             data_out_last,
    output logic [CW-1:0]    data_out_len
);
    localparam int IW = $clog2(BURST_LEN);

    typedef enum logic {COLLECT = 1'b0, SEND = 1'b1} state_t;

    state_t                          state, state_nxt;
    logic [BURST_LEN-1:0][WIDTH-1:0] buf_q;
    logic [CW-1:0]                   wr_cnt, len;
    logic [IW-1:0]                   rd_idx;
    logic                            accept, fire, full_accept, timeout_hit, is_last;

    assign accept      = data_in_val && data_in_rdy;
    assign fire        = data_out_val && data_out_rdy;
    assign full_accept = accept && (wr_cnt == CW'(BURST_LEN - 1));
    assign is_last     = (CW'(rd_idx) == len - CW'(1));

`ifdef FIFO_BURST_READER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] idle_cnt;

    // An accept on the expiry cycle wins, so the flush is qualified with !accept.
    assign timeout_hit = (state == COLLECT) && (wr_cnt != '0) && !accept &&
                         (idle_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset || state != COLLECT || wr_cnt == '0 || accept || timeout_hit)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + TW'(1);
    end
`else
    // Without the idle counter TIMEOUT has no effect.
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= COLLECT;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            COLLECT: if (full_accept || timeout_hit) state_nxt = SEND;
            SEND:    if (fire && is_last)            state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    // Outputs depend only on registered state, so there is no data_out_rdy -> data_in_rdy path.
    always_comb begin
        data_in_rdy   = 1'b0;
        data_out_val  = 1'b0;
        data_out      = '0;
        data_out_last = 1'b0;
        data_out_len  = '0;
        if (!reset) begin
            unique case (state)
                COLLECT: data_in_rdy = 1'b1;
                SEND: begin
                    data_out_val  = 1'b1;
                    data_out      = buf_q[rd_idx];
                    data_out_last = is_last;
                    data_out_len  = len;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_cnt <= '0;
            rd_idx <= '0;
            len    <= '0;
        end else begin
            if (accept) wr_cnt <= wr_cnt + CW'(1);
            if (full_accept) begin
                len    <= CW'(BURST_LEN);
                rd_idx <= '0;
            end else if (timeout_hit) begin
                len    <= wr_cnt;
                rd_idx <= '0;
            end
            // rd_idx returns to 0 on the final beat so it stays within [0, len-1].
            if (fire) begin
                if (is_last) begin
                    wr_cnt <= '0;
                    rd_idx <= '0;
                end else begin
                    rd_idx <= rd_idx + IW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) buf_q[wr_cnt[IW-1:0]] <= data_in;
    end

endmodule
